// File: rtl/edge_event_arbiter.sv
// Multi-channel edge detector with one pending slot per channel, round-robin
// onto a single valid/ready event port. Define EDGE_ARB_SYNC_EN to add 2-flop input synchronizers.

module edge_event_lane (
    input  logic clk,
    input  logic reset,
    input  logic primed,
    input  logic d,
    input  logic rise_en,
    input  logic fall_en,
    input  logic gnt,
    input  logic ovf_clr,
    output logic pend,
    output logic pend_type,
    output logic overflow
);
    logic d_s, d_q, rise, fall, qual, drop;

`ifdef EDGE_ARB_SYNC_EN
    logic s1, s2;
    always_ff @(posedge clk) begin
        if (!reset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
        end else begin
            s1 <= d;
            s2 <= s1;
        end
    end
    assign d_s = s2;
`else
    assign d_s = d;
`endif

    assign rise = d_s & ~d_q;
    assign fall = ~d_s & d_q;
    assign qual = primed & ((rise & rise_en) | (fall & fall_en));
    // a grant in the same cycle frees the slot, so the new event reloads it
    assign drop = qual & pend & ~gnt;

    always_ff @(posedge clk) begin
        if (!reset) begin
            d_q       <= 1'b0;
            pend      <= 1'b0;
            pend_type <= 1'b0;
            overflow  <= 1'b0;
        end else begin
            d_q <= d_s;
            if (qual && !drop) begin
                pend      <= 1'b1;
                pend_type <= rise;
            end else if (gnt) begin
                pend <= 1'b0;
            end
            if (drop)
                overflow <= 1'b1;
            else if (ovf_clr)
                overflow <= 1'b0;
        end
    end
endmodule

module edge_event_arbiter #(
    parameter int N_CH = 4,
    parameter int CH_W = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [N_CH-1:0] d,
    input  logic [N_CH-1:0] cfg_rise_en,
    input  logic [N_CH-1:0] cfg_fall_en,
    input  logic            evt_ready,
    output logic            evt_valid,
    output logic [CH_W-1:0] evt_ch,
    output logic            evt_type,
    input  logic            ovf_clr,
    output logic [N_CH-1:0] overflow
);
`ifdef EDGE_ARB_SYNC_EN
    localparam int STAGES = 2;
`else
    localparam int STAGES = 0;
`endif

    logic [STAGES:0]  vld_pipe;
    logic             primed;
    logic [N_CH-1:0]  pend, pend_type, gnt_vec;
    logic [CH_W-1:0]  rr_ptr, gnt_idx, cand_idx;
    logic             found, slot_free;

    assign primed    = vld_pipe[STAGES];
    assign slot_free = ~evt_valid | evt_ready;

    edge_event_lane u_lane [N_CH-1:0] (
        .clk       (clk),
        .reset     (reset),
        .primed    (primed),
        .d         (d),
        .rise_en   (cfg_rise_en),
        .fall_en   (cfg_fall_en),
        .gnt       (gnt_vec),
        .ovf_clr   (ovf_clr),
        .pend      (pend),
        .pend_type (pend_type),
        .overflow  (overflow)
    );

    // first pending channel strictly after rr_ptr, wrapping at N_CH
    always_comb begin
        found    = 1'b0;
        gnt_idx  = '0;
        cand_idx = '0;
        gnt_vec  = '0;
        for (int off = 1; off <= N_CH; off++) begin
            cand_idx = CH_W'((int'(rr_ptr) + off) % N_CH);
            if (!found && pend[cand_idx]) begin
                found   = 1'b1;
                gnt_idx = cand_idx;
            end
        end
        if (slot_free && found)
            gnt_vec[gnt_idx] = 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            vld_pipe  <= '0;
            evt_valid <= 1'b0;
            evt_ch    <= '0;
            evt_type  <= 1'b0;
            rr_ptr    <= CH_W'(N_CH - 1);
        end else begin
            vld_pipe <= (vld_pipe << 1) | (STAGES+1)'(1);
            if (slot_free) begin
                if (found) begin
                    evt_valid <= 1'b1;
                    evt_ch    <= gnt_idx;
                    evt_type  <= pend_type[gnt_idx];
                    rr_ptr    <= gnt_idx;
                end else begin
                    evt_valid <= 1'b0;
                end
            end
        end
    end
endmodule

// File: tb/tb_edge_event_arbiter.sv
// Randomized and directed bench for edge_event_arbiter against a behavioural model.
module tb_edge_event_arbiter;
    localparam int N_CH = 4;
    localparam int CH_W = 2;
`ifdef EDGE_ARB_SYNC_EN
    localparam int SYNC = 1;
    localparam int LAT  = 3;
`else
    localparam int SYNC = 0;
    localparam int LAT  = 1;
`endif
    localparam int PRIME = LAT;

    logic            clk = 1'b0;
    logic            reset = 1'b0;
    logic [N_CH-1:0] d = '0, cfg_rise_en = '0, cfg_fall_en = '0;
    logic            evt_ready = 1'b0, ovf_clr = 1'b0;
    logic            evt_valid, evt_type;
    logic [CH_W-1:0] evt_ch;
    logic [N_CH-1:0] overflow;

    int vectors = 0;
    int miscompares = 0;

    // behavioural reference state
    bit            m_v, m_t;
    bit [CH_W-1:0] m_ch;
    bit [N_CH-1:0] m_pend, m_pt, m_ovf, m_dq, m_s1, m_s2;
    int            m_ptr, m_cnt;

    edge_event_arbiter #(.N_CH(N_CH), .CH_W(CH_W)) dut (
        .clk(clk), .reset(reset), .d(d), .cfg_rise_en(cfg_rise_en),
        .cfg_fall_en(cfg_fall_en), .evt_ready(evt_ready), .evt_valid(evt_valid),
        .evt_ch(evt_ch), .evt_type(evt_type), .ovf_clr(ovf_clr), .overflow(overflow)
    );

    always #5 clk = ~clk;

    task automatic model_update();
        bit [N_CH-1:0] smp;
        bit primed, rise, fall, ev;
        int g;
        if (!reset) begin
            m_v = 0; m_t = 0; m_ch = '0; m_pend = '0; m_pt = '0; m_ovf = '0;
            m_dq = '0; m_s1 = '0; m_s2 = '0; m_cnt = 0; m_ptr = N_CH - 1;
            return;
        end
        smp    = (SYNC != 0) ? m_s2 : d;
        primed = (m_cnt >= PRIME);
        g = -1;
        if (!m_v || evt_ready) begin
            for (int off = 1; off <= N_CH; off++)
                if (g < 0 && m_pend[(m_ptr + off) % N_CH]) g = (m_ptr + off) % N_CH;
            if (g >= 0) begin
                m_v = 1; m_ch = CH_W'(g); m_t = m_pt[g]; m_ptr = g; m_pend[g] = 0;
            end else m_v = 0;
        end
        for (int i = 0; i < N_CH; i++) begin
            rise = smp[i] && !m_dq[i];
            fall = !smp[i] && m_dq[i];
            ev   = primed && ((rise && cfg_rise_en[i]) || (fall && cfg_fall_en[i]));
            if (ev && m_pend[i]) m_ovf[i] = 1;
            else begin
                if (ovf_clr) m_ovf[i] = 0;
                if (ev) begin m_pend[i] = 1; m_pt[i] = rise; end
            end
        end
        m_dq = smp; m_s2 = m_s1; m_s1 = d;
        if (m_cnt < PRIME) m_cnt++;
    endtask

    task automatic step();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic test_reset();
        reset = 0; d = '1; cfg_rise_en = '1; cfg_fall_en = '1; evt_ready = 1; ovf_clr = 0;
        step(); step();
        vectors++;
        if ({evt_valid, evt_ch, evt_type, overflow} !== '0) begin
            miscompares++;
            $display("FAIL reset_state: got %h expected 0", {evt_valid, evt_ch, evt_type, overflow});
        end
        reset = 1;
        for (int c = 0; c < 10; c++) begin
            step();
            vectors++;
            if (evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL reset_release_quiet: cycle %0d valid %b expected 0", c, evt_valid);
            end
        end
    endtask

    task automatic test_single_rise();
        cfg_rise_en = '0; cfg_fall_en = '0; d = '0;
        repeat (4) step();
        cfg_rise_en = 4'b0001; d = 4'b0001;
        step();
        for (int c = 1; c <= LAT + 1; c++) begin
            step();
            vectors++;
            if (evt_valid !== (c == LAT) ||
                (c == LAT && (evt_ch !== 2'd0 || evt_type !== 1'b1))) begin
                miscompares++;
                $display("FAIL single_rise_latency: k+%0d got v=%b ch=%0d t=%b expected v=%b ch=0 t=1",
                         c, evt_valid, evt_ch, evt_type, c == LAT);
            end
        end
        d = '0;
        for (int c = 0; c < LAT + 2; c++) begin
            step();
            vectors++;
            if (evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL fall_disabled: got valid %b expected 0", evt_valid);
            end
        end
    endtask

    task automatic test_burst();
        int q[$];
        reset = 0; d = '0; cfg_rise_en = '1; cfg_fall_en = '0; evt_ready = 1;
        step(); reset = 1;
        repeat (5) step();
        for (int b = 0; b < 2; b++) begin
            q.delete();
            d = '1;
            step();
            for (int c = 0; c < LAT + 5; c++) begin
                step();
                if (evt_valid) q.push_back(int'(evt_ch));
            end
            vectors++;
            if (q.size() != 4) begin
                miscompares++;
                $display("FAIL burst_count: burst %0d got %0d events expected 4", b, q.size());
            end
            for (int i = 0; i < q.size() && i < 4; i++) begin
                vectors++;
                if (q[i] != i) begin
                    miscompares++;
                    $display("FAIL burst_order: burst %0d slot %0d got ch %0d expected %0d", b, i, q[i], i);
                end
            end
            d = '0;
            repeat (LAT + 2) step();
        end
    endtask

    task automatic test_overflow();
        cfg_rise_en = 4'b0100; cfg_fall_en = 4'b0100; evt_ready = 0; d = '0;
        repeat (LAT + 2) step();
        d = 4'b0100;
        repeat (LAT + 1) step();
        vectors++;
        if ({evt_valid, evt_ch, evt_type} !== {1'b1, 2'd2, 1'b1}) begin
            miscompares++;
            $display("FAIL ovf_first_present: got v=%b ch=%0d t=%b expected 1/2/1", evt_valid, evt_ch, evt_type);
        end
        d = '0;
        repeat (LAT + 1) step();
        d = 4'b0100;
        repeat (LAT + 1) step();
        vectors++;
        if ({evt_valid, evt_ch, evt_type, overflow} !== {1'b1, 2'd2, 1'b1, 4'b0100}) begin
            miscompares++;
            $display("FAIL ovf_hold_and_flag: got v=%b ch=%0d t=%b ovf=%b expected 1/2/1/0100",
                     evt_valid, evt_ch, evt_type, overflow);
        end
        evt_ready = 1;
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_type} !== {1'b1, 2'd2, 1'b0}) begin
            miscompares++;
            $display("FAIL ovf_second_fall: got v=%b ch=%0d t=%b expected 1/2/0", evt_valid, evt_ch, evt_type);
        end
        step();
        vectors++;
        if ({evt_valid, overflow} !== {1'b0, 4'b0100}) begin
            miscompares++;
            $display("FAIL ovf_drained: got v=%b ovf=%b expected 0/0100", evt_valid, overflow);
        end
        ovf_clr = 1;
        step();
        ovf_clr = 0;
        vectors++;
        if (overflow !== 4'b0000) begin
            miscompares++;
            $display("FAIL ovf_clear: got %b expected 0000", overflow);
        end
    endtask

    task automatic test_reset_mid();
        cfg_rise_en = '1; cfg_fall_en = '1; evt_ready = 0;
        d = 4'b1011;
        repeat (LAT + 2) step();
        d = 4'b0100;
        repeat (LAT + 2) step();
        vectors++;
        if (evt_valid !== 1'b1 || overflow === 4'b0000) begin
            miscompares++;
            $display("FAIL mid_precondition: got v=%b ovf=%b expected v=1 ovf nonzero", evt_valid, overflow);
        end
        reset = 0;
        step();
        vectors++;
        if ({evt_valid, evt_ch, evt_type, overflow} !== '0) begin
            miscompares++;
            $display("FAIL mid_reset_state: got %h expected 0", {evt_valid, evt_ch, evt_type, overflow});
        end
        reset = 1; evt_ready = 1;
        for (int c = 0; c < 12; c++) begin
            step();
            vectors++;
            if (evt_valid !== 1'b0) begin
                miscompares++;
                $display("FAIL mid_no_stale: cycle %0d valid %b expected 0", c, evt_valid);
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            if ($urandom_range(0, 2) == 0) d = N_CH'($urandom);
            if ($urandom_range(0, 15) == 0) begin
                cfg_rise_en = N_CH'($urandom);
                cfg_fall_en = N_CH'($urandom);
            end
            evt_ready = ($urandom_range(0, 3) != 0);
            ovf_clr   = ($urandom_range(0, 15) == 0);
            reset     = ($urandom_range(0, 79) != 0);
            step();
            vectors++;
            if ({evt_valid, evt_ch, evt_type, overflow} !== {m_v, m_ch, m_t, m_ovf}) begin
                miscompares++;
                $display("FAIL random_model: cycle %0d got v=%b ch=%0d t=%b ovf=%b expected v=%b ch=%0d t=%b ovf=%b",
                         c, evt_valid, evt_ch, evt_type, overflow, m_v, m_ch, m_t, m_ovf);
            end
        end
        reset = 1; ovf_clr = 0;
    endtask

    initial begin
        test_reset();
        test_single_rise();
        test_burst();
        test_overflow();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/edge_event_arbiter.md
Name: edge_event_arbiter

Overview:
Multi-channel edge detector and event scheduler. Watches N_CH single-bit input signals and detects rising and falling transitions, each type enabled per channel. Holds one pending event per channel. Shares a single event output port among all channels using round-robin arbitration and a valid/ready handshake. Sits between raw status or handshake lines and a single downstream consumer, such as an interrupt or logging block.

Parameters:
N_CH, 4, number of monitored channels (2..16)
CH_W, 2, width of channel index; must equal ceil(log2(N_CH))

Ports:
clk  input  1  system clock; all logic on posedge
reset  input  1  synchronous, active-low reset (0 = reset asserted)
d  input  N_CH  monitored signals, one bit per channel
cfg_rise_en  input  N_CH  per-channel enable for rising-edge events
cfg_fall_en  input  N_CH  per-channel enable for falling-edge events
evt_ready  input  1  consumer accepts the current event
evt_valid  output  1  event present on evt_ch/evt_type
evt_ch  output  CH_W  channel index of the presented event
evt_type  output  1  1 = rise, 0 = fall
ovf_clr  input  1  clears all overflow flags
overflow  output  N_CH  sticky per-channel flag: an event was dropped

Behaviour:
- Reset (reset==0 at posedge): evt_valid=0, evt_ch=0, evt_type=0, overflow=0, all pending bits=0, d_q=0, primed=0, rr_ptr=N_CH-1.
- Edge detection:
  - d_q <= d every cycle.
  - rise_i = d[i] & ~d_q[i]; fall_i = ~d[i] & d_q[i].
  - Both are gated by primed, which goes to 1 at the first posedge after reset release. No spurious events from reset values.
- Qualified event on channel i: (rise_i & cfg_rise_en[i]) | (fall_i & cfg_fall_en[i]).
- Pending:
  - A qualified event sets pend[i] and pend_type[i] = rise_i.
  - If pend[i] is already 1 and is not being granted this cycle, the new event is dropped. The stored type is kept and overflow[i] is set.
  - If pend[i] is granted in the same cycle a new event arrives, pend[i] is reloaded with the new event and no overflow occurs.
- Output slot (registered):
  - The slot is free when evt_valid==0 or (evt_valid & evt_ready).
  - When free and any pend is 1: grant the first pending channel searching upward from rr_ptr+1, modulo N_CH.
  - On grant: evt_valid<=1, evt_ch<=grant, evt_type<=pend_type[grant], clear pend[grant], rr_ptr<=grant.
  - When free and nothing is pending: evt_valid<=0.
- Handshake:
  - evt_ch and evt_type are held stable while evt_valid & ~evt_ready.
  - Back-to-back transfers are allowed: with evt_ready held at 1, one event per cycle.
- Latency: d[i] first sampled changed at posedge k, with the slot free and no contention → pend set at k, evt_valid=1 after posedge k+1.
- Simultaneous events:
  - Multiple channels pending at once: served in round-robin order, at most one grant per cycle.
  - A channel re-toggling inside one cycle is invisible; d is sampled only at posedge.
- ovf_clr: clears all overflow bits at the next posedge. A drop in the same cycle wins, so that bit stays 1.
- Config changes take effect on the next detection. Clearing an enable does not purge an existing pending event.
- Reset mid-operation: all pending and in-flight events are discarded; state returns to reset values on that posedge.

Optional Feature:
- Macro EDGE_ARB_SYNC_EN.
- Defined:
  - Each d bit passes through a 2-flop synchronizer (reset to 0) before the detection register.
  - primed is asserted only after 3 posedges following reset release.
  - Latency increases by 2 cycles (evt_valid after posedge k+3).
- Undefined: d is treated as already synchronous to clk, with the latency stated above.

Test Plan:
1. Reset release with d=4'b1111 and all enables 1 → no event at any time; evt_valid stays 0 for 10 cycles.
2. cfg_rise_en=4'b0001, evt_ready=1; d[0] goes 0→1 at posedge k → evt_valid=1, evt_ch=0, evt_type=1 for exactly one cycle after posedge k+1. The following fall of d[0] produces no event.
3. All channels rise in the same cycle, evt_ready=1, rr_ptr at reset → events ch0, ch1, ch2, ch3 on consecutive cycles. A second burst is then served starting from ch0 again, because rr_ptr=3 wraps to 0.
4. evt_ready=0, ch2 rise pending then ch2 fall → the rise is presented and held stable. The fall is stored pending. A third toggle sets overflow[2]=1. After ready: rise, then fall are delivered; ovf_clr pulse → overflow=0.
5. Events in flight with evt_valid=1 and pend bits set, then reset=0 for one cycle → evt_valid=0, overflow=0, no stale events delivered afterward.
6. With EDGE_ARB_SYNC_EN defined, repeat scenario 2 → evt_valid appears after posedge k+3.
